// File: rtl/spi_fl_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_fl_seq
//  Brief    : Flash operation sequencer. Expands READ / PROGRAM / ERASE
//             requests into WREN, main command and RDSR polling on the
//             spi_master_fl command interface, returning one response each.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_fl_seq #(
   parameter logic [15:0] POLL_MAX = 16'd1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [23:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] m_data_in,
   output logic [23:0] m_address,
   output logic [7:0]  m_command,
   output logic [2:0]  m_commtype,
   output logic [6:0]  m_nmiso_bits,
   output logic        m_validflag,
   input  logic [31:0] m_data_out,
   input  logic        m_validflag_out,
   input  logic        m_tready
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WREN = 3'd1,
      ST_MAIN = 3'd2,
      ST_POLL = 3'd3,
      ST_RESP = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      PH_ISSUE  = 2'd0,
      PH_ACCEPT = 2'd1,
      PH_DONE   = 2'd2
   } phase_t;

   localparam logic [1:0] c_OP_READ  = 2'b00;
   localparam logic [1:0] c_OP_PROG  = 2'b01;
   localparam logic [1:0] c_OP_ERASE = 2'b10;

   state_t      state_q, state_d;
   phase_t      phase_q, phase_d;
   logic [1:0]  op_q, op_d;
   logic [23:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [15:0] poll_q, poll_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic        cap_q, cap_d;
   logic [31:0] capdata_q, capdata_d;
   logic        vfo_q;

   logic        w_rise;
   logic        w_answer;
   logic        w_got;
   logic [31:0] w_ans_data;
   logic        w_step_done;
   logic        w_busy;

   assign w_rise      = m_validflag_out & ~vfo_q;
   assign w_answer    = ((state_q == ST_MAIN) && (op_q == c_OP_READ)) || (state_q == ST_POLL);
   assign w_got       = cap_q | w_rise;
   assign w_ans_data  = w_rise ? m_data_out : capdata_q;
   assign w_step_done = (phase_q == PH_DONE) && m_tready && (!w_answer || w_got);
   assign w_busy      = (state_q == ST_WREN) || (state_q == ST_MAIN) || (state_q == ST_POLL);

   // State and datapath registers; reset abandons any sequence immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         phase_q   <= PH_ISSUE;
         op_q      <= 2'b00;
         addr_q    <= 24'd0;
         wdata_q   <= 32'd0;
         poll_q    <= 16'd0;
         err_q     <= 1'b0;
         rdata_q   <= 32'd0;
         cap_q     <= 1'b0;
         capdata_q <= 32'd0;
         vfo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         poll_q    <= poll_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         cap_q     <= cap_d;
         capdata_q <= capdata_d;
         vfo_q     <= m_validflag_out;
      end
   end

   // Master command buses are a pure function of the current step, so they stay stable for the whole step
   always_comb begin
      req_ready    = (state_q == ST_IDLE);
      resp_valid   = (state_q == ST_RESP);
      resp_err     = (state_q == ST_RESP) & err_q;
      resp_rdata   = rdata_q;
      m_data_in    = 32'd0;
      m_address    = 24'd0;
      m_command    = 8'h00;
      m_commtype   = 3'b000;
      m_nmiso_bits = 7'd0;
      m_validflag  = w_busy && (((phase_q == PH_ISSUE) && m_tready) || (phase_q == PH_ACCEPT));
      case (state_q)
         ST_WREN: begin
            m_command  = 8'h06;
            m_commtype = 3'b000;
         end
         ST_MAIN: begin
            case (op_q)
               c_OP_READ: begin
                  m_command    = 8'h03;
                  m_commtype   = 3'b010;
                  m_address    = addr_q;
                  m_nmiso_bits = 7'd32;
               end
               c_OP_PROG: begin
                  m_command  = 8'h02;
                  m_commtype = 3'b100;
                  m_address  = addr_q;
                  m_data_in  = wdata_q;
               end
               c_OP_ERASE: begin
                  m_command  = 8'h20;
                  m_commtype = 3'b101;
                  m_address  = addr_q;
               end
               default: ;
            endcase
         end
         ST_POLL: begin
            m_command    = 8'h05;
            m_commtype   = 3'b001;
            m_nmiso_bits = 7'd8;
         end
         default: ;
      endcase
   end

   // Sequencing: top-level step selection plus the issue/accept/done handshake within each step
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      op_d      = op_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      poll_d    = poll_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      cap_d     = cap_q;
      capdata_d = capdata_q;

      // Answer data is latched only on the rising edge of validflag_out while waiting for it
      if (w_busy && (phase_q == PH_DONE) && w_answer && w_rise) begin
         cap_d     = 1'b1;
         capdata_d = m_data_out;
      end

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               err_d   = 1'b0;
               poll_d  = 16'd0;
               phase_d = PH_ISSUE;
               cap_d   = 1'b0;
               case (req_op)
                  c_OP_READ:  state_d = ST_MAIN;
                  c_OP_PROG,
                  c_OP_ERASE: state_d = ST_WREN;
                  default: begin
                     state_d = ST_RESP;
                     err_d   = 1'b1;
                  end
               endcase
            end
         end
         ST_WREN, ST_MAIN, ST_POLL: begin
            case (phase_q)
               PH_ISSUE: begin
                  if (m_tready) begin
                     phase_d = PH_ACCEPT;
                     if (state_q == ST_POLL) begin
                        poll_d = poll_q + 16'd1;
                     end
                  end
               end
               PH_ACCEPT: begin
                  if (!m_tready) begin
                     phase_d = PH_DONE;
                  end
               end
               PH_DONE: begin
                  if (w_step_done) begin
                     phase_d = PH_ISSUE;
                     cap_d   = 1'b0;
                     if (state_q == ST_WREN) begin
                        state_d = ST_MAIN;
                     end else if (state_q == ST_MAIN) begin
                        if (op_q == c_OP_READ) begin
                           rdata_d = w_ans_data;
                           state_d = ST_RESP;
                        end else begin
                           poll_d  = 16'd0;
                           state_d = ST_POLL;
                        end
                     end else begin
                        // WIP is bit 0 of the status byte, which arrives in the top byte
                        if (!w_ans_data[24]) begin
                           state_d = ST_RESP;
                        end else if (poll_q >= POLL_MAX) begin
                           err_d   = 1'b1;
                           state_d = ST_RESP;
                        end
                     end
                  end
               end
               default: phase_d = PH_ISSUE;
            endcase
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            phase_d = PH_ISSUE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_fl_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_fl_seq
//  Brief    : Scoreboard bench for spi_fl_seq with a behavioural master/flash
//             model and a request-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_fl_seq;

   localparam logic [15:0] PMAX = 16'd4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [23:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] m_data_in;
   logic [23:0] m_address;
   logic [7:0]  m_command;
   logic [2:0]  m_commtype;
   logic [6:0]  m_nmiso_bits;
   logic        m_validflag;
   logic [31:0] m_data_out;
   logic        m_validflag_out;
   logic        m_tready;

   spi_fl_seq #(.POLL_MAX(PMAX)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .m_data_in(m_data_in), .m_address(m_address), .m_command(m_command),
      .m_commtype(m_commtype), .m_nmiso_bits(m_nmiso_bits), .m_validflag(m_validflag),
      .m_data_out(m_data_out), .m_validflag_out(m_validflag_out), .m_tready(m_tready)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   int last_resp_cyc = -10;

   logic [73:0] exp_cmd[$];
   logic [32:0] exp_resp[$];
   logic [31:0] last_rdata;
   int          wip_polls;
   logic [31:0] read_data;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [73:0] cmdv(input logic [7:0] c, input logic [2:0] t,
                                        input logic [23:0] a, input logic [31:0] d,
                                        input logic [6:0] n);
      return {c, t, a, d, n};
   endfunction

   // Reference model: what one request should look like on the master bus and as a response
   task automatic expect_req(input logic [1:0] op, input logic [23:0] a, input logic [31:0] d);
      int np;
      if (op == 2'b00) begin
         exp_cmd.push_back(cmdv(8'h03, 3'b010, a, 32'd0, 7'd32));
         last_rdata = read_data;
         exp_resp.push_back({1'b0, read_data});
      end else if (op == 2'b11) begin
         exp_resp.push_back({1'b1, last_rdata});
      end else begin
         exp_cmd.push_back(cmdv(8'h06, 3'b000, 24'd0, 32'd0, 7'd0));
         if (op == 2'b01) exp_cmd.push_back(cmdv(8'h02, 3'b100, a, d, 7'd0));
         else             exp_cmd.push_back(cmdv(8'h20, 3'b101, a, 32'd0, 7'd0));
         np = (wip_polls < int'(PMAX)) ? wip_polls + 1 : int'(PMAX);
         for (int i = 0; i < np; i++) exp_cmd.push_back(cmdv(8'h05, 3'b001, 24'd0, 32'd0, 7'd8));
         exp_resp.push_back({(wip_polls >= int'(PMAX)), last_rdata});
      end
   endtask

   // Master + flash model: checks each issued command against the scoreboard and plays the handshake
   int          mst;
   int          dly;
   int          busy;
   int          plen;
   int          poll_idx;
   logic        prev_vf;
   logic        cur_ans;
   logic [31:0] ans_q;
   always @(negedge clk or posedge rst) begin : mdl
      logic [73:0] v_cmd;
      logic [31:0] v_ans;
      if (rst) begin
         m_tready        <= 1'b1;
         m_validflag_out <= 1'b0;
         m_data_out      <= 32'd0;
         mst             <= 0;
         prev_vf         <= 1'b0;
         poll_idx        <= 0;
         dly             <= 0;
         busy            <= 0;
         plen            <= 0;
         cur_ans         <= 1'b0;
         ans_q           <= 32'd0;
      end else begin
         prev_vf <= m_validflag;
         case (mst)
            0: begin
               if (m_validflag && !prev_vf) begin
                  v_cmd = {m_command, m_commtype, m_address, m_data_in, m_nmiso_bits};
                  if (exp_cmd.size() == 0) begin
                     vectors++; errors++;
                     $display("FAIL cmd_unexpected: got %h expected none", v_cmd);
                  end else begin
                     chk("cmd", v_cmd, exp_cmd.pop_front());
                  end
                  cur_ans <= (m_command == 8'h03) || (m_command == 8'h05);
                  if (m_command == 8'h05) begin
                     v_ans     = $urandom;
                     v_ans[24] = (poll_idx < wip_polls);
                     poll_idx <= poll_idx + 1;
                  end else begin
                     v_ans    = read_data;
                     poll_idx <= 0;
                  end
                  ans_q <= v_ans;
                  dly   <= $urandom_range(0, 2);
                  mst   <= 1;
               end else if (m_validflag && prev_vf) begin
                  vectors++; errors++;
                  $display("FAIL vf_gap: got validflag held across commands expected low gap");
               end
            end
            1: begin
               chk("vf_hold", m_validflag, 1'b1);
               if (dly == 0) begin
                  m_tready <= 1'b0;
                  busy     <= $urandom_range(1, 4);
                  mst      <= 2;
               end else begin
                  dly <= dly - 1;
               end
            end
            2: begin
               chk("vf_low_busy", m_validflag, 1'b0);
               if (busy > 1) begin
                  busy <= busy - 1;
               end else if (cur_ans) begin
                  m_data_out      <= ans_q;
                  m_validflag_out <= 1'b1;
                  plen            <= $urandom_range(1, 3);
                  mst             <= 3;
               end else begin
                  m_data_out      <= $urandom;
                  m_validflag_out <= 1'b1;
                  mst             <= 4;
               end
            end
            3: begin
               chk("vf_low_ans", m_validflag, 1'b0);
               if (plen > 1) begin
                  plen <= plen - 1;
               end else begin
                  m_validflag_out <= 1'b0;
                  m_data_out      <= $urandom;
                  m_tready        <= 1'b1;
                  mst             <= 0;
               end
            end
            default: begin
               chk("vf_low_end", m_validflag, 1'b0);
               m_validflag_out <= 1'b0;
               m_tready        <= 1'b1;
               mst             <= 0;
            end
         endcase
      end
   end

   // Response monitor: pops the scoreboard whenever the DUT presents a response
   logic prev_rv = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_rv) chk("resp_pulse", resp_valid, 1'b0);
         if (resp_valid) begin
            last_resp_cyc = cyc;
            if (exp_resp.size() == 0) begin
               vectors++; errors++;
               $display("FAIL resp_unexpected: got err=%b rdata=%h expected none", resp_err, resp_rdata);
            end else begin
               chk("resp", {resp_err, resp_rdata}, exp_resp.pop_front());
               if (exp_resp.size() == 0) chk("cmds_left", exp_cmd.size(), 0);
            end
         end
         prev_rv <= resp_valid;
      end else begin
         prev_rv <= 1'b0;
      end
   end

   // Drive one request from a negedge; returns at the negedge after acceptance
   task automatic send(input logic [1:0] op, input logic [23:0] a, input logic [31:0] d,
                       input bit hold, input bit b2b);
      int n;
      expect_req(op, a, d);
      req_op    = op;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         vectors++; errors++;
         $display("FAIL accept_timeout: got req_ready=0 expected 1");
         req_valid = 1'b0;
         return;
      end
      if (b2b) chk("b2b_accept", cyc - last_resp_cyc, 1);
      @(posedge clk);
      @(negedge clk);
      if (op == 2'b11) begin
         chk("illegal_vf", m_validflag, 1'b0);
         chk("illegal_resp", {resp_valid, resp_err}, 2'b11);
      end else begin
         chk("issue_latency", m_validflag, 1'b1);
      end
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_resp.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         vectors++; errors++;
         $display("FAIL resp_timeout: got %0d responses pending expected 0", exp_resp.size());
         exp_resp.delete();
         exp_cmd.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_op     = 2'b00;
      req_addr   = 24'd0;
      req_wdata  = 32'd0;
      wip_polls  = 0;
      read_data  = 32'd0;
      last_rdata = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {req_ready, resp_valid, resp_err, m_validflag}, 4'b1000);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_bus", {m_command, m_commtype, m_address, m_data_in, m_nmiso_bits}, 74'd0);
      rst = 1'b0;
      @(negedge clk);

      read_data = 32'hDEADBEEF;
      send(2'b00, 24'h000100, 32'd0, 1'b0, 1'b0);
      wait_idle();
      wip_polls = 2;
      send(2'b01, 24'h000040, 32'h12345678, 1'b0, 1'b0);
      wait_idle();
      wip_polls = 1000;
      send(2'b10, 24'h003000, 32'd0, 1'b0, 1'b0);
      wait_idle();
      send(2'b11, 24'h00ABCD, 32'h0, 1'b0, 1'b0);
      wait_idle();

      // Reset while polling
      wip_polls = 1000;
      send(2'b10, 24'h005000, 32'd0, 1'b0, 1'b0);
      n = 0;
      while (!(m_validflag && m_command == 8'h05) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         vectors++; errors++;
         $display("FAIL poll_wait: got no RDSR expected RDSR issue");
      end
      rst = 1'b1;
      #1;
      chk("rst_mid_vf", m_validflag, 1'b0);
      chk("rst_mid_ready", req_ready, 1'b1);
      exp_cmd.delete();
      exp_resp.delete();
      last_rdata = 32'd0;
      req_valid  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      read_data = $urandom;
      send(2'b00, 24'h0A0B0C, 32'd0, 1'b0, 1'b0);
      wait_idle();

      // Back-to-back with req_valid held high
      read_data = $urandom;
      wip_polls = 1;
      send(2'b00, 24'h111111, 32'd0, 1'b1, 1'b0);
      send(2'b01, 24'h222222, 32'hCAFEF00D, 1'b0, 1'b1);
      wait_idle();

      // Randomized requests
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  r_op;
         logic [23:0] r_addr;
         logic [31:0] r_data;
         r_op      = 2'($urandom_range(0, 3));
         r_addr    = 24'($urandom);
         r_data    = $urandom;
         wip_polls = $urandom_range(0, 5);
         read_data = $urandom;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(r_op, r_addr, r_data, 1'b0, 1'b0);
         wait_idle();
      end

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
